// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM target with programmable wait states
// and a one-cycle memReady completion pulse.
module mem_responder #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memoryReadEn,
  input  logic              memoryWriteEn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              memReady,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              op_wr;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign cnt_nxt = cnt + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      op_wr    <= 1'b0;
      readData <= '0;
      memReady <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (memoryWriteEn || memoryReadEn) begin
            addr_q <= address;
            data_q <= writeData;
            // a write wins when both enables are raised together
            op_wr  <= memoryWriteEn;
            busy   <= 1'b1;
            cnt    <= '0;
            if (WAIT_CYCLES == 0) state <= S_ACCESS;
            else                  state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == WAIT_LAST) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!op_wr) readData <= mem[addr_q];
          memReady <= 1'b1;
          state    <= S_RESP;
        end
        S_RESP: begin
          memReady <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM array has no reset; reset keeps state out of ACCESS
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && op_wr) mem[addr_q] <= data_q;
  end

  a_no_wait_state: assert property (
    @(posedge clk) disable iff (!rst)
    (WAIT_CYCLES != 0) || (state != S_WAIT));

  a_single_ready: assert property (
    @(posedge clk) disable iff (!rst)
    memReady |=> !memReady);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus
// randomized traffic against an associative-array memory model.
module tb_mem_responder;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int W  = 2;
  // memReady is seen after the (W+1)th edge following the capture edge
  localparam int LAT  = W + 1;
  localparam int BUSY = W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          rdy, bsy;
  logic          rd0, wr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          rdy0, bsy0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] last_rd;
  logic [AW-1:0] pool [8] = '{13'h0000, 13'h0001, 13'h0002, 13'h0010,
                              13'h0555, 13'h0100, 13'h1FFE, 13'h1FFF};

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .memoryReadEn(rd), .memoryWriteEn(wr),
    .address(addr), .writeData(wdata),
    .readData(rdata), .memReady(rdy), .busy(bsy)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .memoryReadEn(rd0), .memoryWriteEn(wr0),
    .address(addr0), .writeData(wdata0),
    .readData(rdata0), .memReady(rdy0), .busy(bsy0)
  );

  task automatic txn(input bit w, input bit r,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] rv, output int lat,
                     output int bc, output bit after);
    bit got;
    @(negedge clk);
    wr = w; rd = r; addr = a; wdata = d;
    @(posedge clk); #1;
    lat = 0; got = 0; rv = 'x;
    bc = bsy ? 1 : 0;
    addr = ~a; wdata = ~d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bsy) bc++;
      if (rdy) begin got = 1; rv = rdata; end
    end
    wr = 0; rd = 0;
    @(posedge clk); #1;
    after = rdy;
  endtask

  task automatic test_reset();
    int seen;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", rdy); end
    checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bsy); end
    checks++; if ({rdata0, rdy0, bsy0} !== 10'd0) begin errors++; $display("FAIL rst_nowait: got %h expected 000", {rdata0, rdy0, bsy0}); end
    @(negedge clk);
    rst = 1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rdy || bsy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", seen); end
    last_rd = 8'h00;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rv;
    int lat, bc;
    bit after;
    txn(1, 0, 13'h0010, 8'hA5, rv, lat, bc, after);
    model[13'h0010] = 8'hA5;
    checks++; if (lat !== LAT) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bc !== BUSY) begin errors++; $display("FAIL wr_busy: got %0d expected %0d", bc, BUSY); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b expected 0", after); end
    checks++; if (rv !== last_rd) begin errors++; $display("FAIL wr_keeps_rdata: got %h expected %h", rv, last_rd); end
    txn(0, 1, 13'h0010, 8'h00, rv, lat, bc, after);
    last_rd = 8'hA5;
    checks++; if (rv !== 8'hA5) begin errors++; $display("FAIL rd_data: got %h expected a5", rv); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bc !== BUSY) begin errors++; $display("FAIL rd_busy: got %0d expected %0d", bc, BUSY); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL rd_pulse: got %b expected 0", after); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] rv;
    int lat, bc;
    bit after;
    txn(1, 1, 13'h1FFF, 8'h3C, rv, lat, bc, after);
    model[13'h1FFF] = 8'h3C;
    checks++; if (rv !== last_rd) begin errors++; $display("FAIL both_keeps_rdata: got %h expected %h", rv, last_rd); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL both_latency: got %0d expected %0d", lat, LAT); end
    txn(0, 1, 13'h1FFF, 8'h00, rv, lat, bc, after);
    last_rd = 8'h3C;
    checks++; if (rv !== 8'h3C) begin errors++; $display("FAIL both_readback: got %h expected 3c", rv); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rv;
    logic [DW-1:0] got [2];
    int lat, bc, n, gap;
    bit after;
    txn(1, 0, 13'h0000, 8'h11, rv, lat, bc, after);
    model[13'h0000] = 8'h11;
    txn(1, 0, 13'h0001, 8'h22, rv, lat, bc, after);
    model[13'h0001] = 8'h22;
    @(negedge clk);
    rd = 1; addr = 13'h0000;
    n = 0; gap = 0;
    got[0] = 'x; got[1] = 'x;
    for (int i = 0; i < 60 && n < 2; i++) begin
      @(posedge clk); #1;
      if (n == 1) gap++;
      if (rdy) begin
        got[n] = rdata;
        n++;
        if (n == 1) addr = 13'h0001;
        else rd = 0;
      end
    end
    rd = 0;
    last_rd = 8'h22;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n); end
    checks++; if (gap !== W + 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", gap, W + 3); end
    checks++; if (got[0] !== 8'h11) begin errors++; $display("FAIL b2b_first: got %h expected 11", got[0]); end
    checks++; if (got[1] !== 8'h22) begin errors++; $display("FAIL b2b_second: got %h expected 22", got[1]); end
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b expected 0", rdy); end
  endtask

  task automatic test_random();
    logic [DW-1:0] rv, d, exp;
    logic [AW-1:0] a;
    int lat, bc;
    bit after, w, both;
    for (int k = 0; k < 30; k++) begin
      a = pool[$urandom_range(0, 7)];
      d = DW'($urandom_range(0, 255));
      w = ($urandom_range(0, 2) == 0) || !model.exists(int'(a));
      both = w && ($urandom_range(0, 3) == 0);
      txn(w, !w || both, a, d, rv, lat, bc, after);
      if (w) begin
        exp = last_rd;
        model[int'(a)] = d;
      end else begin
        exp = model[int'(a)];
        last_rd = exp;
      end
      checks++; if (rv !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", k, rv, exp); end
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, LAT); end
    end
  endtask

  task automatic test_abort();
    logic [DW-1:0] rv;
    int lat, bc, seen;
    bit after;
    txn(1, 0, 13'h0020, 8'h00, rv, lat, bc, after);
    model[13'h0020] = 8'h00;
    @(negedge clk);
    wr = 1; addr = 13'h0020; wdata = 8'hFF;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if ({rdy, bsy} !== 2'b00) begin errors++; $display("FAIL abort_outputs: got %b expected 00", {rdy, bsy}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata: got %h expected 00", rdata); end
    wr = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    last_rd = 8'h00;
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (rdy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ready: got %0d pulses expected 0", seen); end
    txn(0, 1, 13'h0020, 8'h00, rv, lat, bc, after);
    checks++; if (rv !== 8'h00) begin errors++; $display("FAIL abort_ram: got %h expected 00", rv); end
  endtask

  task automatic test_nowait();
    logic [DW-1:0] rv;
    int lat, bc;
    bit got;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wr0 = (k == 0); rd0 = (k == 1);
      addr0 = 13'h0ABC; wdata0 = 8'h5A;
      @(posedge clk); #1;
      lat = 0; got = 0; rv = 'x;
      bc = bsy0 ? 1 : 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge clk); #1;
        lat++;
        if (bsy0) bc++;
        if (rdy0) begin got = 1; rv = rdata0; end
      end
      wr0 = 0; rd0 = 0;
      checks++; if (lat !== 1) begin errors++; $display("FAIL nowait_latency[%0d]: got %0d expected 1", k, lat); end
      checks++; if (bc !== 2) begin errors++; $display("FAIL nowait_busy[%0d]: got %0d expected 2", k, bc); end
      if (k == 1) begin
        checks++; if (rv !== 8'h5A) begin errors++; $display("FAIL nowait_data: got %h expected 5a", rv); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rd = 0; wr = 0; addr = '0; wdata = '0;
    rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    last_rd = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_abort();
    test_nowait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
